// File: rtl/switch_debounce_irq_ctrl_pkg.sv
// Shared definitions for the slide-switch debounce/interrupt controller:
// register offsets, reset debounce period and the per-bit debounce state type.
package soc_switch_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    localparam int DEFAULT_PERIOD = 50000;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_t;

endpackage

// File: rtl/switch_debounce_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the switch controller register file.
interface switch_debounce_irq_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/switch_debounce_irq_ctrl_bit.sv
// One switch line: 2-flop synchroniser, debounce FSM with a run-length counter,
// and a single-cycle toggle pulse on the cycle the debounced level commits.
module switch_debounce_bit
    import soc_switch_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic [CNT_W-1:0] period,
    output logic             deb,
    output logic             toggle
);

    logic             s1, s;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_d;
    logic [CNT_W-1:0] pmax;
    logic [CNT_W:0]   run_nxt;
    logic             commit;

    // The counter holds how many differing samples were seen before this one,
    // so the level commits on the PERIOD-th consecutive differing sample.
    assign pmax    = (period == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : period;
    assign run_nxt = (state_q == ST_STABLE) ? {{CNT_W{1'b0}}, 1'b1}
                                            : {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign commit  = run_nxt >= {1'b0, pmax};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            s       <= 1'b0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            deb     <= 1'b0;
        end else begin
            s1      <= din;
            s       <= s1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb     <= deb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb;
        toggle  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s != deb) begin
                    if (commit) begin
                        deb_d  = s;
                        toggle = 1'b1;
                    end else begin
                        state_d = ST_COUNTING;
                        cnt_d   = run_nxt[CNT_W-1:0];
                    end
                end
            end
            ST_COUNTING: begin
                if (s == deb) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (commit) begin
                    deb_d   = s;
                    toggle  = 1'b1;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = run_nxt[CNT_W-1:0];
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

endmodule

// File: rtl/switch_debounce_irq_ctrl.sv
// Avalon-MM switch controller: per-line debounce, edge capture with W1C,
// maskable level interrupt and a registered read mux.
module switch_debounce_irq_ctrl #(
    parameter int WIDTH          = 4,
    parameter int CNT_W          = 20,
    parameter int DEFAULT_PERIOD = soc_switch_pkg::DEFAULT_PERIOD
) (
    input  logic                        clk,
    input  logic                        reset,
    switch_debounce_irq_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0]            in_port,
    output logic                        irq
);

    import soc_switch_pkg::*;

    logic [WIDTH-1:0] deb, tog, mask_q, edge_q, edge_clr;
    logic [CNT_W-1:0] period_q;
    logic             wr;
    logic [31:0]      rd_mux;

    assign wr = bus.chipselect & ~bus.write_n;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        switch_debounce_bit #(.CNT_W(CNT_W)) u_bit (
            .clk    (clk),
            .reset  (reset),
            .din    (in_port[g]),
            .period (period_q),
            .deb    (deb[g]),
            .toggle (tog[g])
        );
    end

    assign edge_clr = (wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:   rd_mux[WIDTH-1:0] = deb;
            ADDR_MASK:   rd_mux[WIDTH-1:0] = mask_q;
            ADDR_EDGE:   rd_mux[WIDTH-1:0] = edge_q;
            ADDR_PERIOD: rd_mux[CNT_W-1:0] = period_q;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q       <= '0;
            edge_q       <= '0;
            period_q     <= CNT_W'(DEFAULT_PERIOD);
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr && bus.address == ADDR_MASK)   mask_q   <= bus.writedata[WIDTH-1:0];
            if (wr && bus.address == ADDR_PERIOD) period_q <= bus.writedata[CNT_W-1:0];
            // A toggle in the same cycle as its W1C keeps the bit set.
            edge_q       <= (edge_q & ~edge_clr) | tog;
            irq          <= |(edge_q & mask_q);
            bus.readdata <= rd_mux;
        end
    end

endmodule
